// File: rtl/endstop_capture.sv
// endstop_capture
// Captures locked endstop events from a debouncer into a small FIFO, then
// hands the debouncer a one-cycle release pulse. Latches an abort flag when a
// captured event matches the armed active level.
//
// States:
//   state     | meaning
//   IDLE      | waiting for a locked event from the debouncer
//   RELEASE   | event captured, unlock pulse is on the wire this cycle
//   WAIT_DROP | waiting for the debouncer to drop its stale sig_changed
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   sig_changed         locked-event flag from the debouncer
//   sig_level           debounced level that goes with the event
//   pos_in[63:0]        position latched by the debouncer
//   cycles_in[7:0]      debouncer transition counter
//   unlock              one-cycle release pulse back to the debouncer
//   enable, polarity    abort arming and active level
//   abort_clear         clears the abort latch
//   rd                  host pop strobe
//   ev_valid/ev_pos/ev_level/ev_cycles   head entry of the queue
//   count[4:0]          entries queued, 0..DEPTH
//   stalled             an event is waiting because the queue is full
//   abort               sticky abort latch
//
// DEPTH must be a power of two between 2 and 16 so the pointers wrap on
// their own and count fits in five bits.

module endstop_capture #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sig_changed,
  input  logic        sig_level,
  input  logic [63:0] pos_in,
  input  logic [7:0]  cycles_in,
  output logic        unlock,
  input  logic        enable,
  input  logic        polarity,
  input  logic        abort_clear,
  input  logic        rd,
  output logic        ev_valid,
  output logic [63:0] ev_pos,
  output logic        ev_level,
  output logic [7:0]  ev_cycles,
  output logic [4:0]  count,
  output logic        stalled,
  output logic        abort
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RELEASE   = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t          state_q;
  logic            unlock_q;
  logic            stalled_q, stalled_d;
  logic            abort_q, abort_d;
  logic [4:0]      count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [72:0]     mem_q [DEPTH];
  logic [72:0]     head;
  logic            full, push, pop;

  // Eligibility uses the registered count, so a pop in the same cycle does
  // not make room for a push until the next cycle.
  assign full = (count_q == DEPTH_C);
  assign push = (state_q == IDLE) && sig_changed && !full;
  assign pop  = rd && (count_q != 5'd0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    stalled_d = stalled_q;
    if (push)
      stalled_d = 1'b0;
    else if ((state_q == IDLE) && sig_changed && full)
      stalled_d = 1'b1;
  end

  // A set on a matching push wins over a coincident clear.
  always_comb begin
    abort_d = abort_q;
    if (push && enable && (sig_level == polarity))
      abort_d = 1'b1;
    else if (abort_clear)
      abort_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      unlock_q <= 1'b0;
    end else begin
      unlock_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (push) begin
            unlock_q <= 1'b1;
            state_q  <= RELEASE;
          end
        end
        RELEASE:   state_q <= WAIT_DROP;
        // Holding here while the flag is still high stops one event from
        // being captured twice.
        WAIT_DROP: if (!sig_changed) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 5'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      stalled_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      stalled_q <= stalled_d;
      abort_q   <= abort_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pos_in, sig_level, cycles_in};
  end

  assign head      = mem_q[rd_ptr_q];
  assign ev_valid  = (count_q != 5'd0);
  assign ev_pos    = ev_valid ? head[72:9] : 64'd0;
  assign ev_level  = ev_valid ? head[8]    : 1'b0;
  assign ev_cycles = ev_valid ? head[7:0]  : 8'd0;

  assign unlock  = unlock_q;
  assign count   = count_q;
  assign stalled = stalled_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_endstop_capture.sv
// Testbench for endstop_capture: directed scenarios followed by randomized
// debouncer-like traffic. A behavioural model predicts status and queued
// events; a separate monitor compares DUT outputs against those predictions.

module tb_endstop_capture;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig_changed = 1'b0, sig_level = 1'b0;
  logic [63:0] pos_in = 64'd0;
  logic [7:0]  cycles_in = 8'd0;
  logic        enable = 1'b0, polarity = 1'b0, abort_clear = 1'b0, rd = 1'b0;
  logic        unlock, ev_valid, ev_level, stalled, abort;
  logic [63:0] ev_pos;
  logic [7:0]  ev_cycles;
  logic [4:0]  count;

  endstop_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sig_changed(sig_changed), .sig_level(sig_level),
    .pos_in(pos_in), .cycles_in(cycles_in), .unlock(unlock), .enable(enable),
    .polarity(polarity), .abort_clear(abort_clear), .rd(rd), .ev_valid(ev_valid),
    .ev_pos(ev_pos), .ev_level(ev_level), .ev_cycles(ev_cycles), .count(count),
    .stalled(stalled), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pos;
    logic        lvl;
    logic [7:0]  cyc;
  } ev_t;

  typedef struct packed {
    logic [4:0] cnt;
    logic       unl;
    logic       stl;
    logic       abt;
  } st_t;

  ev_t sb[$];
  st_t stq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: event queue occupancy, handshake phase with the
  // debouncer (0 ready, 1 just captured, 2 waiting for flag to drop).
  int m_cnt = 0;
  int m_phase = 0;
  bit m_stl = 0, m_abt = 0, m_unl = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic l,
                      input logic [63:0] p, input logic [7:0] c,
                      input logic e, input logic po, input logic cl, input logic rdi);
    bit  psh, pp;
    ev_t ne;
    st_t ns;
    @(negedge clk);
    #1;
    reset = r; sig_changed = s; sig_level = l; pos_in = p; cycles_in = c;
    enable = e; polarity = po; abort_clear = cl; rd = r ? 1'b0 : rdi;
    if (r) begin
      m_cnt = 0; m_phase = 0; m_stl = 0; m_abt = 0; m_unl = 0;
      sb.delete();
    end else begin
      psh = (m_phase == 0) && s && (m_cnt < DEPTH);
      pp  = rdi && (m_cnt > 0);
      if (psh) m_stl = 0;
      else if ((m_phase == 0) && s) m_stl = 1;
      if (psh && e && (l == po)) m_abt = 1;
      else if (cl) m_abt = 0;
      case (m_phase)
        0:       if (psh) m_phase = 1;
        1:       m_phase = 2;
        default: if (!s) m_phase = 0;
      endcase
      m_unl = psh;
      if (psh) m_cnt++;
      if (pp)  m_cnt--;
      if (psh) begin
        ne = '{pos: p, lvl: l, cyc: c};
        sb.push_back(ne);
      end
    end
    ns = '{cnt: 5'(m_cnt), unl: m_unl, stl: m_stl, abt: m_abt};
    stq.push_back(ns);
  endtask

  // Debouncer-style event: flag held for 'hold' cycles, then dropped once.
  task automatic event_in(input logic [63:0] p, input logic l, input logic [7:0] c,
                          input int hold, input logic e, input logic po, input logic rdi);
    for (int i = 0; i < hold; i++) step(0, 1, l, p, c, e, po, 0, (i == 0) ? rdi : 1'b0);
    step(0, 0, l, p, c, e, po, 0, 0);
  endtask

  // Monitor: compares status every cycle and the head entry whenever valid.
  initial begin
    bit  prev_valid;
    st_t e;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (rd && prev_valid) begin
        if (sb.size() == 0) chk("pop_with_empty_scoreboard", 64'd1, 64'd0);
        else void'(sb.pop_front());
      end
      if (stq.size() > 0) begin
        e = stq.pop_front();
        chk("count",    64'(count),    64'(e.cnt));
        chk("ev_valid", 64'(ev_valid), 64'(e.cnt != 5'd0));
        chk("unlock",   64'(unlock),   64'(e.unl));
        chk("stalled",  64'(stalled),  64'(e.stl));
        chk("abort",    64'(abort),    64'(e.abt));
      end
      if (ev_valid) begin
        if (sb.size() == 0) chk("head_without_expected_entry", 64'd1, 64'd0);
        else begin
          chk("ev_pos",    ev_pos,         sb[0].pos);
          chk("ev_level",  64'(ev_level),  64'(sb[0].lvl));
          chk("ev_cycles", 64'(ev_cycles), 64'(sb[0].cyc));
        end
      end else begin
        chk("ev_pos_idle",    ev_pos,         64'd0);
        chk("ev_level_idle",  64'(ev_level),  64'd0);
        chk("ev_cycles_idle", 64'(ev_cycles), 64'd0);
      end
      prev_valid = ev_valid;
    end
  end

  initial begin
    int   hold;
    logic s, l, e, po, cl, rdi, r;
    logic [63:0] p;
    logic [7:0]  c;

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single event, then pop it.
    step(0, 1, 1, 64'h1234, 8'd3, 0, 0, 0, 0);
    step(0, 1, 1, 64'h1234, 8'd3, 0, 0, 0, 0);
    step(0, 0, 1, 64'h1234, 8'd3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Overflow: four events fill the queue, fifth stalls until one pop.
    for (int i = 0; i < 4; i++) event_in(64'h100 + 64'(i), 1'(i), 8'(i), 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 64'h555, 8'd9, 0, 0, 0, 0);
    step(0, 1, 0, 64'h555, 8'd9, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 64'h555, 8'd9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Stale flag held long after the unlock: one capture only.
    event_in(64'hABCD, 1, 8'd7, 7, 0, 0, 0);

    // Concurrent push and pop with one entry already queued.
    event_in(64'h2222, 0, 8'd2, 2, 0, 0, 0);
    event_in(64'h3333, 1, 8'd4, 2, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Abort: matching capture sets it; clear coinciding with a second match.
    event_in(64'h44, 0, 8'd1, 2, 1, 0, 0);
    step(0, 1, 0, 64'h45, 8'd2, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset while in RELEASE, flag still high afterwards is a new event.
    step(0, 1, 1, 64'h77, 8'd5, 1, 1, 0, 0);
    step(1, 1, 1, 64'h77, 8'd5, 1, 1, 0, 0);
    step(0, 1, 1, 64'h78, 8'd6, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized debouncer traffic.
    s = 0; hold = 1; l = 0; p = 0; c = 0; e = 0; po = 0;
    for (int i = 0; i < 3000; i++) begin
      hold--;
      if (hold <= 0) begin
        s = ~s;
        hold = s ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 4));
        if (s) begin
          p = {$urandom(), $urandom()};
          c = 8'($urandom());
          l = 1'($urandom());
        end
      end
      if ($urandom_range(0, 19) == 0) e  = 1'($urandom());
      if ($urandom_range(0, 29) == 0) po = 1'($urandom());
      cl  = ($urandom_range(0, 19) == 0);
      rdi = ($urandom_range(0, 99) < 22);
      r   = ($urandom_range(0, 299) == 0);
      step(r, s, l, p, c, e, po, cl, rdi);
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/endstop_capture.md
ENDSTOP_CAPTURE -- requirements
Module: endstop_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event queue depth in entries; only power of two, 2..16.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sig_changed, input, 1, locked-event flag from the debouncer.
REQ-005 SHALL have port sig_level, input, 1, debounced level accompanying sig_changed.
REQ-006 SHALL have port pos_in, input, 64, latched position from the debouncer.
REQ-007 SHALL have port cycles_in, input, 8, debouncer transition counter.
REQ-008 SHALL have port unlock, output, 1, registered one-cycle release pulse to the debouncer.
REQ-009 SHALL have ports enable and polarity, input, 1 each: abort arming and active level.
REQ-010 SHALL have port abort_clear, input, 1, clears the abort latch.
REQ-011 SHALL have port rd, input, 1, host pop strobe.
REQ-012 SHALL have ports ev_valid (1), ev_pos (64), ev_level (1), ev_cycles (8), outputs, head entry of queue.
REQ-013 SHALL have ports count (5), stalled (1), abort (1), outputs.

Function
REQ-014 SHALL run FSM states IDLE, RELEASE, WAIT_DROP.
REQ-015 IDLE, sig_changed=1 and count<DEPTH: push {pos_in, sig_level, cycles_in}, unlock<=1, go RELEASE.
REQ-016 IDLE, sig_changed=1 and count=DEPTH: no push, no unlock, stalled<=1, stay IDLE. The debouncer stays locked and keeps counting.
REQ-017 stalled SHALL clear in the cycle a push occurs.
REQ-018 RELEASE: unlock<=0, go WAIT_DROP unconditionally. unlock is high for exactly one cycle, the cycle after the push.
REQ-019 WAIT_DROP: sig_changed=0 goes IDLE. sig_changed=1 stays in WAIT_DROP with no push. This prevents double capture of one event.
REQ-020 Queue SHALL be FIFO with wrap-around pointers. count ranges 0..DEPTH.
REQ-021 Head outputs SHALL be valid when ev_valid=1. ev_valid=(count!=0).
REQ-022 rd with ev_valid=1 SHALL pop the head. Head data updates the next cycle.
REQ-023 rd with count=0 SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL leave count unchanged. Data order is preserved.
REQ-025 Push eligibility SHALL use the registered count, including in a pop cycle. A full queue with rd does not push that cycle; it pushes next cycle.
REQ-026 abort SHALL set on a push when enable=1 and sig_level=polarity.
REQ-027 abort SHALL clear on abort_clear=1.
REQ-028 When a set and abort_clear coincide, the set SHALL win.
REQ-029 abort SHALL be sticky otherwise, and unaffected by enable deasserting.
REQ-030 Push latency: sig_changed high at cycle N produces ev_valid and count update at N+1 and unlock=1 at N+1.

Reset
REQ-031 reset SHALL force state IDLE, unlock=0, count=0, ev_valid=0, stalled=0, abort=0, and both pointers to 0.
REQ-032 ev_pos, ev_level and ev_cycles SHALL read 0 after reset.
REQ-033 reset mid-operation, including RELEASE, SHALL drop the unlock pulse and discard all queued entries.
REQ-034 After reset deasserts, a still-high sig_changed SHALL be captured as a new event.

Verification
REQ-035 Single event: sig_changed=1 at N, pos_in=0x1234, sig_level=1, cycles_in=3 -> at N+1 ev_valid=1, ev_pos=0x1234, ev_cycles=3, unlock=1; at N+2 unlock=0. Debouncer drops sig_changed at N+2 -> IDLE at N+3.
REQ-036 Overflow: 4 events with no rd -> count=4; 5th sig_changed held -> stalled=1, no unlock; one rd -> count=3, then push, unlock pulse, stalled=0, count=4.
REQ-037 Stale flag: sig_changed held high 5 cycles after unlock -> exactly one push, FSM stays in WAIT_DROP until it drops.
REQ-038 Concurrent: count=2, push and rd in the same cycle -> count stays 2; pop order matches push order with wrap past index 3.
REQ-039 Abort: enable=1, polarity=0, event with sig_level=0 -> abort=1 at N+1; abort_clear coinciding with a second matching push -> abort stays 1.
REQ-040 Reset in RELEASE -> next cycle unlock=0, count=0, ev_valid=0, abort=0.
